ddr_line_responder_model: RTL and testbench

// - Responder end of the cache/DDR line-request interface: behavioural DDR line store answering one 256-bit read/write command at a time.
// - Stands in for the DDR2 controller so cache-side initiators (cache, Icache/Dcache traffic generators) are exercised in sim and on-chip without the MIG.
// - Fixed, parameterised latency; single-cycle ready pulse; optional latency jitter.

---
 rtl/ddr_line_responder_model.sv | 76 +++++++
 tb/tb_ddr_line_responder_model.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ddr_line_responder_model.sv
// ddr_line_responder_model: fixed-latency 256-bit DDR line store responder, optional latency jitter via DDR_LINE_RESP_JITTER_EN
module ddr_line_responder_model #(
  parameter int DEPTH      = 64,
  parameter int ADDR_LSB   = 3,
  parameter int WR_LATENCY = 8,
  parameter int RD_LATENCY = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] mem_data_wr1,
  output logic [255:0] mem_data_rd1,
  input  logic [27:0]  mem_data_addr1,
  input  logic         mem_rw_data1,
  input  logic         mem_valid_data1,
  output logic         mem_ready_data1,
  output logic         busy,
  output logic         protocol_err
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d, lat;
  logic [IW-1:0] idx_q, idx_d;
  logic rw_q, rw_d, ready_q, ready_d, busy_q, busy_d, err_q, err_d, done, accept;
  logic [255:0] wdata_q, wdata_d, rd_q, rd_d;
  logic [255:0] mem [DEPTH];
  logic unused_addr;
  assign unused_addr = ^mem_data_addr1;
`ifdef DDR_LINE_RESP_JITTER_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge clk)
    lfsr_q <= rst ? 8'hA5 : {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign lat = (mem_rw_data1 ? 7'(WR_LATENCY) : 7'(RD_LATENCY)) + {5'd0, lfsr_q[1:0]};
`else
  assign lat = mem_rw_data1 ? 7'(WR_LATENCY) : 7'(RD_LATENCY);
`endif
  assign accept = state_q == IDLE && mem_valid_data1;
  assign done   = state_q == BUSY && cnt_q == 7'd1;
  always_comb begin
    state_d = accept ? BUSY : done ? RESP : state_q == RESP ? IDLE : state_q;
    cnt_d   = accept ? lat : state_q == BUSY ? cnt_q - 7'd1 : cnt_q;
    idx_d   = accept ? mem_data_addr1[ADDR_LSB +: IW] : idx_q;
    rw_d    = accept ? mem_rw_data1 : rw_q;
    wdata_d = accept ? mem_data_wr1 : wdata_q;
    rd_d    = done && !rw_q ? mem[idx_q] : rd_q;
    ready_d = done;
    busy_d  = state_d != IDLE;
    err_d   = err_q | (state_q == BUSY && !mem_valid_data1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
    idx_q   <= idx_d;
    rw_q    <= rw_d;
    wdata_q <= wdata_d;
  end
  always_ff @(posedge clk)
    if (!rst && done && rw_q) mem[idx_q] <= wdata_q;
  assign mem_data_rd1    = rd_q;
  assign mem_ready_data1 = ready_q;
  assign busy            = busy_q;
  assign protocol_err    = err_q;
endmodule

// File: tb/tb_ddr_line_responder_model.sv
// tb_ddr_line_responder_model: timeline model of the line responder checked every cycle plus literal pins
module tb_ddr_line_responder_model;
  localparam logic [255:0] D1 = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  localparam logic [255:0] DA = {8{32'hAAAA5555}};
  localparam logic [255:0] DB = {8{32'hBBBB0123}};
  localparam logic [255:0] D2 = {8{32'hDEADBEEF}};
  logic clk = 0, rst = 1, rw = 0, valid = 0;
  logic [27:0] addr = '0;
  logic [255:0] wd = '0, rd;
  logic ready, busy, perr;
  int checks = 0, errors = 0, cyc = 0;
  logic busy_m = 0, ready_m = 0, err_m = 0, rw_m = 0;
  int t_acc = 0, lat_m = 0, idx_m = 0, extra = 0;
  logic [255:0] wd_m = '0, rd_m = '0;
  logic [255:0] mem_m [64];
  logic [7:0] lfsr_m = 8'hA5;
  ddr_line_responder_model dut (
    .clk(clk), .rst(rst), .mem_data_wr1(wd), .mem_data_rd1(rd), .mem_data_addr1(addr),
    .mem_rw_data1(rw), .mem_valid_data1(valid), .mem_ready_data1(ready), .busy(busy),
    .protocol_err(perr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      busy_m = 0; ready_m = 0; err_m = 0; rd_m = '0; lfsr_m = 8'hA5;
    end else begin
      ready_m = 0;
`ifdef DDR_LINE_RESP_JITTER_EN
      extra = int'(lfsr_m[1:0]);
`else
      extra = 0;
`endif
      lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
      if (busy_m) begin
        if (cyc <= t_acc + lat_m && !valid) err_m = 1;
        if (cyc == t_acc + lat_m) begin
          ready_m = 1;
          if (rw_m) mem_m[idx_m] = wd_m;
          else rd_m = mem_m[idx_m];
        end
        if (cyc == t_acc + lat_m + 1) busy_m = 0;
      end else if (valid) begin
        busy_m = 1; t_acc = cyc; rw_m = rw; idx_m = int'(addr[8:3]); wd_m = wd;
        lat_m = (rw ? 8 : 12) + extra;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("ready", 256'(ready), 256'(ready_m));
      chk("busy", 256'(busy), 256'(busy_m));
      chk("protocol_err", 256'(perr), 256'(err_m));
      chk("rd_data", rd, rd_m);
    end
  end
  task automatic cmd(input logic r, input logic [27:0] a, input logic [255:0] d, input int drop,
                     output int rc);
    rw = r; addr = a; wd = d; valid = 1; rc = -1;
    for (int i = 1; i <= 100 && rc < 0; i++) begin
      @(negedge clk);
      if (i == drop) valid = 0;
      if (ready) rc = cyc;
    end
    valid = 0;
    chk("ready_seen", 256'(rc >= 0), 256'(1));
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int rc, a0, pulses, bad;
    int hist [4];
    logic [255:0] dw;
    repeat (2) @(negedge clk);
    chk("reset_ready", 256'(ready), 256'(0));
    chk("reset_busy", 256'(busy), 256'(0));
    chk("reset_err", 256'(perr), 256'(0));
    chk("reset_rd", rd, 256'h0);
    rst = 0;
    a0 = cyc + 1;
    cmd(1, 28'h000_1010, D1, 0, rc);
`ifndef DDR_LINE_RESP_JITTER_EN
    chk("wr_latency", 256'(rc - a0), 256'(8));
`endif
    @(negedge clk);
    a0 = cyc + 1;
    cmd(0, 28'h000_1010, '0, 0, rc);
`ifndef DDR_LINE_RESP_JITTER_EN
    chk("rd_latency", 256'(rc - a0), 256'(12));
`endif
    chk("rd_data_1010", rd, D1);
    repeat (3) @(negedge clk);
    chk("rd_data_held", rd, D1);
    cmd(1, 28'h000_0000, DA, 0, rc);
    @(negedge clk);
    cmd(1, 28'h000_0200, DB, 0, rc);
    @(negedge clk);
    cmd(0, 28'h000_0000, '0, 0, rc);
    chk("alias_read", rd, DB);
    @(negedge clk);
    a0 = cyc + 1;
    cmd(0, 28'h000_1010, '0, 3, rc);
    chk("drop_err", 256'(perr), 256'(1));
`ifndef DDR_LINE_RESP_JITTER_EN
    chk("drop_latency", 256'(rc - a0), 256'(12));
`endif
    repeat (4) @(negedge clk);
    chk("err_sticky", 256'(perr), 256'(1));
    rw = 1; addr = 28'h000_1010; wd = D2; valid = 1;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; valid = 0; pulses = 0;
    chk("rst_clears_err", 256'(perr), 256'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("abandoned_pulses", 256'(pulses), 256'(0));
    cmd(0, 28'h000_1010, '0, 0, rc);
    chk("abandoned_write_kept_old", rd, D1);
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 4; k++) hist[k] = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        dw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cmd(1, 28'(((i / 2) % 64) * 8), dw, 0, rc);
      end else begin
        cmd(0, 28'(((i / 2) % 64) * 8), '0, 0, rc);
        chk("loop_rd", rd, dw);
      end
      if (rc - t_acc - (i % 2 == 0 ? 8 : 12) inside {[0:3]}) hist[rc - t_acc - (i % 2 == 0 ? 8 : 12)]++;
      else bad++;
    end
    chk("lat_out_of_range", 256'(bad), 256'(0));
`ifdef DDR_LINE_RESP_JITTER_EN
    for (int k = 0; k < 4; k++) chk("jitter_value_seen", 256'(hist[k] > 0), 256'(1));
`else
    chk("lat_exact", 256'(hist[0]), 256'(200));
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
